// File: rtl/hex_keypad_scanner_if.sv
// hex_keypad_scanner_if
//   Keypad-side and key-report signals of the hex keypad scanner.
//   row       : keypad row lines, active-low, pulled up, asynchronous to clk
//   col       : column strobes, active-low, one bit low at a time
//   key_hex   : code of the last accepted key
//   key_valid : one-cycle strobe, key_hex is new/valid
//   key_held  : high while the accepted key is still held
//   Modports: master = scanner side, slave = keypad/consumer side.
interface hex_keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_hex;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col, key_hex, key_valid, key_held
    );

    modport slave (
        output row,
        input  col, key_hex, key_valid, key_held
    );
endinterface

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner
//   Scans a 4x4 matrix keypad one column at a time, synchronises the row
//   lines, debounces press and release, and reports a single key as a 4-bit
//   hex code with a one-cycle valid strobe.
//   Ports:
//     clk : system clock
//     rst : synchronous reset, active-high
//     kp  : hex_keypad_scanner_if.master (row in; col, key_hex, key_valid,
//           key_held out)
//   Parameters:
//     SCAN_DIV        cycles per column before its rows are sampled (>= 4)
//     DEBOUNCE_CYCLES stable cycles needed to accept press/release (>= 2)
//     REPEAT_DELAY    hold cycles before first auto-repeat strobe
//     REPEAT_RATE     cycles between later auto-repeat strobes
//   Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat while a
//   key is held. Without it, exactly one strobe is issued per press.
module hex_keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic                 clk,
    input  logic                 rst,
    hex_keypad_scanner_if.master kp
);

    localparam int DIV_W = $clog2(SCAN_DIV) + 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_CYCLES);

    // Parameter sanity; elaboration stops on an unusable configuration.
    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 2) begin : g_param_bad
        $error("hex_keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [3:0]       rs_meta, rs;
    logic [1:0]       idx, idx_nx;
    logic [1:0]       rsel, rsel_nx;
    logic [DIV_W-1:0] div_cnt, div_nx;
    logic [DEB_W-1:0] deb_cnt, deb_nx, deb_inc;
    logic [3:0]       hex_q, hex_nx;
    logic             valid_q, valid_nx;
    logic             held_q, held_nx;
    logic [1:0]       low_row;
    logic             row_low;

    // Keypad legend: rows top to bottom, columns left to right.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Lowest-index low row wins when several rows are pressed together.
    always_comb begin
        low_row = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) low_row = 2'(i);
        end
    end

    assign row_low = ~rs[rsel];
    assign deb_inc = deb_cnt + 1'b1;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX) + 1;
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_RATE);

    logic [REP_W-1:0] rep_cnt, rep_nx, rep_inc;
    logic             rep_first, rep_first_nx;

    assign rep_inc = rep_cnt + 1'b1;
`endif

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        rsel_nx  = rsel;
        div_nx   = '0;
        deb_nx   = '0;
        hex_nx   = hex_q;
        valid_nx = 1'b0;
        held_nx  = held_q;
`ifdef KEYPAD_REPEAT_EN
        // Outside HELD the repeat timer sits cleared and armed for the
        // initial delay, so every entry into HELD restarts it.
        rep_nx       = '0;
        rep_first_nx = 1'b1;
`endif
        case (state)
            SCAN: begin
                if (div_cnt == DIV_LAST) begin
                    if (&rs) begin
                        idx_nx = idx + 2'd1;
                    end else begin
                        rsel_nx  = low_row;
                        state_nx = DEB_PRESS;
                    end
                end else begin
                    div_nx = div_cnt + 1'b1;
                end
            end
            DEB_PRESS: begin
                if (row_low) begin
                    if (deb_inc == DEB_DONE) begin
                        hex_nx   = key_map(rsel, idx);
                        valid_nx = 1'b1;
                        held_nx  = 1'b1;
                        state_nx = HELD;
                    end else begin
                        deb_nx = deb_inc;
                    end
                end else begin
                    // Bounce: abandon silently and move on to the next column.
                    idx_nx   = idx + 2'd1;
                    state_nx = SCAN;
                end
            end
            HELD: begin
                if (!row_low) begin
                    state_nx = DEB_RELEASE;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (rep_inc == (rep_first ? REP_FIRST : REP_NEXT)) begin
                        valid_nx     = 1'b1;
                        rep_first_nx = 1'b0;
                    end else begin
                        rep_nx       = rep_inc;
                        rep_first_nx = rep_first;
                    end
`endif
                end
            end
            default: begin // DEB_RELEASE
                if (row_low) begin
                    state_nx = HELD;
                end else if (deb_inc == DEB_DONE) begin
                    held_nx  = 1'b0;
                    idx_nx   = idx + 2'd1;
                    state_nx = SCAN;
                end else begin
                    deb_nx = deb_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_meta <= 4'b1111;
            rs      <= 4'b1111;
            state   <= SCAN;
            idx     <= 2'd0;
            rsel    <= 2'd0;
            div_cnt <= '0;
            deb_cnt <= '0;
            hex_q   <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            rs_meta <= kp.row;
            rs      <= rs_meta;
            state   <= state_nx;
            idx     <= idx_nx;
            rsel    <= rsel_nx;
            div_cnt <= div_nx;
            deb_cnt <= deb_nx;
            hex_q   <= hex_nx;
            valid_q <= valid_nx;
            held_q  <= held_nx;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else begin
            rep_cnt   <= rep_nx;
            rep_first <= rep_first_nx;
        end
    end
`endif

    // idx is registered, so col only changes the cycle after a step.
    assign kp.col       = ~(4'b0001 << idx);
    assign kp.key_hex   = hex_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// tb_hex_keypad_scanner
//   Self-checking bench for hex_keypad_scanner. A physical keypad model turns
//   a pressed-key matrix into row levels from the live column strobes.
//   Expected key codes go into a queue when a press is issued; a monitor pops
//   and compares on every key_valid strobe.
module tb_hex_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int RDELAY   = 20;
    localparam int RRATE    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hex_keypad_scanner_if kif();

    hex_keypad_scanner #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kif.master)
    );

    // key_down[r][c] = 1 when the key at row r, column c is physically pressed.
    logic [3:0][3:0] key_down = '0;
    always_comb begin
        for (int r = 0; r < 4; r++) kif.row[r] = ~|(key_down[r] & ~kif.col);
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [3:0] exp_q[$];
    logic [3:0] model_hex = 4'h0;
    logic [3:0] last_hex  = 4'h0;
    logic       valid_prev = 1'b0;
    logic       held_prev  = 1'b0;
    int         stb_t[$];

    // Key legend as printed on the keypad.
    function automatic logic [3:0] legend(input int r, input int c);
        logic [3:0] tbl [4][4];
        tbl = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                '{4'h4, 4'h5, 4'h6, 4'hB},
                '{4'h7, 4'h8, 4'h9, 4'hC},
                '{4'h0, 4'hF, 4'hE, 4'hD}};
        return tbl[r][c];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (kif.key_valid) begin
                stb_t.push_back(cyc);
                chk("no_back_to_back", {31'd0, valid_prev}, 32'd0);
`ifdef KEYPAD_REPEAT_EN
                if (held_prev) chk("repeat_hex", {28'd0, kif.key_hex}, {28'd0, last_hex});
                else
`endif
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got key_hex=%0h, expected no strobe (t=%0t)",
                             kif.key_hex, $time);
                end else begin
                    chk("strobe_hex", {28'd0, kif.key_hex}, {28'd0, exp_q.pop_front()});
                end
                last_hex = kif.key_hex;
            end
        end
        valid_prev = kif.key_valid;
        held_prev  = kif.key_held;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_key(input int r, input int c);
        exp_q.push_back(legend(r, c));
        model_hex = legend(r, c);
    endtask

    task automatic wait_held(input string name, input logic level, input int budget);
        int n = 0;
        while (kif.key_held !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, kif.key_held}, {31'd0, level});
    endtask

    task automatic wait_col(input string name, input logic [3:0] val, input int budget);
        int n = 0;
        while (kif.col !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {28'd0, kif.col}, {28'd0, val});
    endtask

    // Press long enough to be accepted from any scan phase, then release.
    task automatic press_long(input int r, input int c);
        expect_key(r, c);
        key_down[r][c] = 1'b1;
        repeat (45) @(posedge clk);
        key_down[r][c] = 1'b0;
        wait_held("long_release", 1'b0, 40);
    endtask

    initial begin
        logic [3:0] ec;
        int n;
        int r, c;

        // 1: reset values, then the free-running column walk.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_col",   {28'd0, kif.col}, 32'h0000000E);
        chk("rst_hex",   {28'd0, kif.key_hex}, 32'd0);
        chk("rst_valid", {31'd0, kif.key_valid}, 32'd0);
        chk("rst_held",  {31'd0, kif.key_held}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ec = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            chk("scan_col", {28'd0, kif.col}, {28'd0, ec});
        end

        // 2: key 5 held 40 cycles, then release timing and resume column.
        expect_key(1, 1);
        key_down[1][1] = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t2_held", {31'd0, kif.key_held}, 32'd1);
        key_down[1][1] = 1'b0;
        n = 0;
        while (kif.key_held !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        // Two sync flops plus DEBOUNCE_CYCLES stable cycles, plus a cycle to notice.
        chk("t2_release_cycles_in_range", {31'd0, (n >= DEB + 2 && n <= DEB + 5)}, 32'd1);
        chk("t2_resume_col", {28'd0, kif.col}, 32'h0000000B);
        chk("t2_hex_kept", {28'd0, kif.key_hex}, 32'h5);

        // 3: short glitch on row 0 during column 2 is ignored.
        wait_col("t3_col2", 4'b1011, 20);
        key_down[0][2] = 1'b1;
        repeat (3) @(posedge clk);
        key_down[0][2] = 1'b0;
        wait_col("t3_next_col", 4'b0111, 30);
        chk("t3_hex_kept", {28'd0, kif.key_hex}, 32'h5);
        chk("t3_held", {31'd0, kif.key_held}, 32'd0);

        // 4: corner keys D then 0.
        press_long(3, 3);
        press_long(3, 0);

        // 5: two rows on one column, lowest row wins; partial release is silent.
        expect_key(0, 1);
        key_down[0][1] = 1'b1;
        key_down[2][1] = 1'b1;
        repeat (45) @(posedge clk);
        key_down[2][1] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t5_still_held", {31'd0, kif.key_held}, 32'd1);
        key_down[0][1] = 1'b0;
        wait_held("t5_release", 1'b0, 40);

        // 6: reset while HELD.
        expect_key(1, 1);
        key_down[1][1] = 1'b1;
        wait_held("t6_accept", 1'b1, 50);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        key_down = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_hex = 4'h0;
        @(negedge clk);
        chk("t6_col",   {28'd0, kif.col}, 32'h0000000E);
        chk("t6_hex",   {28'd0, kif.key_hex}, 32'd0);
        chk("t6_held",  {31'd0, kif.key_held}, 32'd0);
        chk("t6_valid", {31'd0, kif.key_valid}, 32'd0);
        repeat (30) @(posedge clk);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat spacing with key 5 held 40 cycles past acceptance.
        stb_t.delete();
        expect_key(1, 1);
        key_down[1][1] = 1'b1;
        wait_held("rep_accept", 1'b1, 50);
        repeat (40) @(negedge clk);
        key_down[1][1] = 1'b0;
        wait_held("rep_release", 1'b0, 40);
        chk("rep_count", stb_t.size(), 32'd5);
        if (stb_t.size() == 5) begin
            chk("rep_t1", stb_t[1] - stb_t[0], RDELAY);
            chk("rep_t2", stb_t[2] - stb_t[0], RDELAY + RRATE);
            chk("rep_t3", stb_t[3] - stb_t[0], RDELAY + 2 * RRATE);
            chk("rep_t4", stb_t[4] - stb_t[0], RDELAY + 3 * RRATE);
        end
`endif

        // Random presses: long ones must report their legend, short ones nothing.
        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            if ($urandom_range(0, 2) != 0) begin
                press_long(r, c);
                chk("rnd_hex", {28'd0, kif.key_hex}, {28'd0, model_hex});
            end else begin
                key_down[r][c] = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                key_down[r][c] = 1'b0;
                repeat (12) @(posedge clk);
                @(negedge clk);
                chk("rnd_short_hex", {28'd0, kif.key_hex}, {28'd0, model_hex});
                chk("rnd_short_held", {31'd0, kif.key_held}, 32'd0);
            end
        end

        repeat (10) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
